// File: rtl/trojan_resp_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : trojan_resp_capture                                           |
// | Summary  : Captures a full ordered input sweep of a DUT, compares it      |
// |            against a golden truth table and compacts it to a CRC.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module trojan_resp_capture #(
    parameter int                  N_IN  = 5,
    parameter int                  SIG_W = 16,
    parameter logic [SIG_W-1:0]    POLY  = 16'h1021,
    parameter logic [SIG_W-1:0]    SEED  = 16'hFFFF
) (
    input  logic                   CK,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   vec_valid,
    input  logic [N_IN-1:0]        vec,
    input  logic                   resp,
    input  logic [(2**N_IN)-1:0]   golden_tt,
    output logic                   busy,
    output logic                   done,
    output logic [(2**N_IN)-1:0]   tt_out,
    output logic [N_IN:0]          mismatch_cnt,
    output logic [N_IN-1:0]        first_mm_idx,
    output logic                   seq_err,
    output logic [SIG_W-1:0]       signature,
    output logic                   pass
);

    localparam int               c_TT_W     = 2**N_IN;
    localparam logic [N_IN-1:0]  c_IDX_MAX  = '1;
    localparam logic [N_IN-1:0]  c_IDX_ONE  = N_IN'(1);
    localparam logic [N_IN:0]    c_MM_ONE   = (N_IN+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t              r_state,  w_state_nxt;
    logic [N_IN-1:0]     r_idx,    w_idx_nxt;
    logic [c_TT_W-1:0]   r_tt,     w_tt_nxt;
    logic [N_IN:0]       r_mm,     w_mm_nxt;
    logic [N_IN-1:0]     r_first,  w_first_nxt;
    logic                r_seq,    w_seq_nxt;
    logic [SIG_W-1:0]    r_sig,    w_sig_nxt;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic                w_fb;

    assign w_fb = r_sig[SIG_W-1] ^ resp;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tt_nxt    = r_tt;
        w_mm_nxt    = r_mm;
        w_first_nxt = r_first;
        w_seq_nxt   = r_seq;
        w_sig_nxt   = r_sig;
        // start has priority over any sample presented in the same cycle
        if (start) begin
            w_state_nxt = S_CAPTURE;
            w_idx_nxt   = '0;
            w_tt_nxt    = '0;
            w_mm_nxt    = '0;
            w_first_nxt = '0;
            w_seq_nxt   = 1'b0;
            w_sig_nxt   = SEED;
        end else if ((r_state == S_CAPTURE) && vec_valid) begin
            if (vec == r_idx) begin
                w_tt_nxt[r_idx] = resp;
                if (resp != golden_tt[r_idx]) begin
                    w_mm_nxt = r_mm + c_MM_ONE;
                    if (r_mm == '0) begin
                        w_first_nxt = r_idx;
                    end
                end
                w_sig_nxt = {r_sig[SIG_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
                if (r_idx == c_IDX_MAX) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt = r_idx + c_IDX_ONE;
                end
            end else begin
                w_seq_nxt = 1'b1;
            end
        end
    end

    // Status flags are derived from next-state values so they are true flops
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_tt    <= '0;
            r_mm    <= '0;
            r_first <= '0;
            r_seq   <= 1'b0;
            r_sig   <= SEED;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_tt    <= w_tt_nxt;
            r_mm    <= w_mm_nxt;
            r_first <= w_first_nxt;
            r_seq   <= w_seq_nxt;
            r_sig   <= w_sig_nxt;
            r_busy  <= (w_state_nxt == S_CAPTURE);
            r_done  <= (w_state_nxt == S_DONE);
            r_pass  <= (w_state_nxt == S_DONE) && (w_mm_nxt == '0) && !w_seq_nxt;
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign tt_out       = r_tt;
    assign mismatch_cnt = r_mm;
    assign first_mm_idx = r_first;
    assign seq_err      = r_seq;
    assign signature    = r_sig;
    assign pass         = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_trojan_resp_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_trojan_resp_capture                                        |
// | Summary  : Self-checking bench: table-driven sweeps with a scoreboard,    |
// |            plus hand-written sequences for ordering/reset/restart cases. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_trojan_resp_capture;

    logic        CK = 1'b0;
    logic        reset;
    logic        start;
    logic        vec_valid;
    logic [4:0]  vec;
    logic        resp;
    logic [31:0] golden_tt;
    logic        busy;
    logic        done;
    logic [31:0] tt_out;
    logic [5:0]  mismatch_cnt;
    logic [4:0]  first_mm_idx;
    logic        seq_err;
    logic [15:0] signature;
    logic        pass;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] golden;
        logic [31:0] resp;
        logic [5:0]  mm;
        logic [4:0]  first;
        logic        pass;
        logic [15:0] sig;
    } vec_t;

    typedef struct {
        logic [31:0] tt;
        logic [5:0]  mm;
        logic [4:0]  first;
        logic        pass;
        logic        seq;
        logic [15:0] sig;
    } exp_t;

    vec_t tbl[5];
    exp_t sb[$];

    trojan_resp_capture #(
        .N_IN  (5),
        .SIG_W (16),
        .POLY  (16'h1021),
        .SEED  (16'hFFFF)
    ) u_dut (
        .CK           (CK),
        .reset        (reset),
        .start        (start),
        .vec_valid    (vec_valid),
        .vec          (vec),
        .resp         (resp),
        .golden_tt    (golden_tt),
        .busy         (busy),
        .done         (done),
        .tt_out       (tt_out),
        .mismatch_cnt (mismatch_cnt),
        .first_mm_idx (first_mm_idx),
        .seq_err      (seq_err),
        .signature    (signature),
        .pass         (pass)
    );

    always #5 CK = ~CK;

    // Byte-oriented CRC-16/CCITT-FALSE; code 0 is the MSB of the first byte
    function automatic logic [15:0] crc_ccitt(input logic [31:0] tt);
        logic [15:0] c;
        logic [7:0]  by;
        c = 16'hFFFF;
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 8; j++) by[7-j] = tt[8*b+j];
            c = c ^ {by, 8'h00};
            for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send(input int code, input logic r);
        @(negedge CK);
        vec_valid = 1'b1;
        vec       = code[4:0];
        resp      = r;
    endtask

    task automatic idle();
        @(negedge CK);
        vec_valid = 1'b0;
    endtask

    task automatic pulse_start(input string tag);
        @(negedge CK);
        start     = 1'b1;
        vec_valid = 1'b0;
        @(negedge CK);
        start = 1'b0;
        chk({tag, "_busy_after_start"}, busy, 1);
        chk({tag, "_done_after_start"}, done, 0);
    endtask

    task automatic wait_done_and_check(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (done !== 1'b1 && n < 8) begin
            @(negedge CK);
            n++;
        end
        chk({tag, "_done"}, done, 1);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard actual=empty required=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_busy"},  busy,         0);
            chk({tag, "_tt"},    tt_out,       e.tt);
            chk({tag, "_mm"},    mismatch_cnt, e.mm);
            chk({tag, "_first"}, first_mm_idx, e.first);
            chk({tag, "_seq"},   seq_err,      e.seq);
            chk({tag, "_sig"},   signature,    e.sig);
            chk({tag, "_pass"},  pass,         e.pass);
        end
    endtask

    task automatic run_sweep(input string tag, input vec_t v);
        exp_t e;
        golden_tt = v.golden;
        e.tt = v.resp; e.mm = v.mm; e.first = v.first;
        e.pass = v.pass; e.seq = 1'b0; e.sig = v.sig;
        sb.push_back(e);
        pulse_start(tag);
        for (int c = 0; c < 31; c++) send(c, v.resp[c]);
        @(negedge CK);
        chk({tag, "_done_early"}, done, 0);
        vec_valid = 1'b1;
        vec       = 5'd31;
        resp      = v.resp[31];
        idle();
        wait_done_and_check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        tbl[0] = '{32'h0000_0000, 32'h0000_0000, 6'd0,  5'd0,  1'b1, 16'h84C0};
        tbl[1] = '{32'hA5A5_0F0F, 32'hA5A5_0F0F, 6'd0,  5'd0,  1'b1, crc_ccitt(32'hA5A5_0F0F)};
        tbl[2] = '{32'hA5A5_0F0F, 32'hA5AD_0F8F, 6'd2,  5'd7,  1'b0, crc_ccitt(32'hA5AD_0F8F)};
        tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 6'd32, 5'd0,  1'b0, 16'h84C0};
        tbl[4] = '{32'h0000_0000, 32'h8000_0000, 6'd1,  5'd31, 1'b0, crc_ccitt(32'h8000_0000)};

        reset = 1'b1; start = 1'b0; vec_valid = 1'b0; vec = '0; resp = 1'b0; golden_tt = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_tt", tt_out, 0);
        chk("rst_sig", signature, 16'hFFFF);
        @(negedge CK);
        @(negedge CK);
        reset = 1'b0;

        // Samples while idle are ignored
        send(0, 1'b1);
        send(3, 1'b1);
        idle();
        chk("idle_busy", busy, 0);
        chk("idle_seq", seq_err, 0);
        chk("idle_tt", tt_out, 0);

        for (int i = 0; i < 5; i++) run_sweep($sformatf("tbl%0d", i), tbl[i]);

        // Samples while done are ignored; results of tbl4 hold
        send(0, 1'b0);
        send(7, 1'b1);
        idle();
        chk("donehold_done", done, 1);
        chk("donehold_tt", tt_out, 32'h8000_0000);
        chk("donehold_mm", mismatch_cnt, 1);
        chk("donehold_seq", seq_err, 0);
        chk("donehold_sig", signature, crc_ccitt(32'h8000_0000));

        // Out-of-order codes 0,1,3 then 2..31
        golden_tt = 32'hA5A5_0F0F;
        pulse_start("ooo");
        send(0, golden_tt[0]);
        send(1, golden_tt[1]);
        send(3, golden_tt[3]);
        idle();
        chk("ooo_seq_err", seq_err, 1);
        chk("ooo_tt_partial", tt_out, 32'h0000_0003);
        chk("ooo_busy", busy, 1);
        e.tt = 32'hA5A5_0F0F; e.mm = 0; e.first = 0; e.pass = 0; e.seq = 1;
        e.sig = crc_ccitt(32'hA5A5_0F0F);
        sb.push_back(e);
        for (int c = 2; c < 32; c++) send(c, golden_tt[c]);
        idle();
        wait_done_and_check("ooo");

        // Asynchronous reset at sample 12
        golden_tt = 32'h0000_0000;
        pulse_start("rstmid");
        for (int c = 0; c < 12; c++) send(c, 1'b1);
        idle();
        #2 reset = 1'b1;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_tt", tt_out, 0);
        chk("rstmid_mm", mismatch_cnt, 0);
        chk("rstmid_sig", signature, 16'hFFFF);
        @(negedge CK);
        reset = 1'b0;
        run_sweep("after_rst", tbl[1]);

        // start together with a sample at code 20
        golden_tt = 32'h0000_0000;
        pulse_start("restart");
        for (int c = 0; c < 20; c++) send(c, 1'b1);
        @(negedge CK);
        start = 1'b1; vec_valid = 1'b1; vec = 5'd20; resp = 1'b1;
        @(negedge CK);
        start = 1'b0; vec_valid = 1'b0;
        chk("restart_tt", tt_out, 0);
        chk("restart_mm", mismatch_cnt, 0);
        chk("restart_sig", signature, 16'hFFFF);
        chk("restart_busy", busy, 1);
        e.tt = 0; e.mm = 0; e.first = 0; e.pass = 1; e.seq = 0; e.sig = 16'h84C0;
        sb.push_back(e);
        for (int c = 0; c < 32; c++) send(c, 1'b0);
        idle();
        wait_done_and_check("restart");

        // start from DONE
        pulse_start("from_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
